// File: rtl/sqrt_reconstruct.sv
// Rebuilds a radicand A = Q*Q + R from an integer root and remainder.
// Iterative shift-add multiplier: one bit of Q is retired per clock, valid/ready on both sides.
module sqrt_reconstruct #(
  parameter int QW = 5,
  parameter int RW = QW + 1,
  parameter int AW = 2 * QW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] q_in,
  input  logic [RW-1:0] r_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] a_out,
  output logic          ovf,
  output logic          rem_err
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   acc_q, acc_d;
  logic [QW-1:0] mcand_q, mcand_d;
  logic [QW-1:0] mult_q, mult_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rem_err_reg_q, rem_err_reg_d;
  logic [AW-1:0] a_out_q, a_out_d;
  logic          ovf_q, ovf_d;
  logic          rem_err_q, rem_err_d;
  logic [AW:0]   addend;

  // Partial product for the current multiplier bit; the extra top bit keeps the sum from wrapping.
  assign addend = {{(AW + 1 - QW){1'b0}}, mcand_q} << cnt_q;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mult_d        = mult_q;
    cnt_d         = cnt_q;
    rem_err_reg_d = rem_err_reg_q;
    a_out_d       = a_out_q;
    ovf_d         = ovf_q;
    rem_err_d     = rem_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d         = {{(AW + 1 - RW){1'b0}}, r_in};
          mcand_d       = q_in;
          mult_d        = q_in;
          cnt_d         = '0;
          rem_err_reg_d = (r_in > {q_in, 1'b0});
          state_d       = RUN;
        end
      end
      RUN: begin
        if (mult_q[0]) begin
          acc_d = acc_q + addend;
        end
        mult_d = mult_q >> 1;
        if (cnt_q == CW'(QW - 1)) begin
          // Final bit: publish the completed sum; outputs stay frozen until the next op finishes.
          state_d   = DONE;
          a_out_d   = acc_d[AW-1:0];
          ovf_d     = acc_d[AW];
          rem_err_d = rem_err_reg_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mult_q        <= '0;
      cnt_q         <= '0;
      rem_err_reg_q <= 1'b0;
      a_out_q       <= '0;
      ovf_q         <= 1'b0;
      rem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mult_q        <= mult_d;
      cnt_q         <= cnt_d;
      rem_err_reg_q <= rem_err_reg_d;
      a_out_q       <= a_out_d;
      ovf_q         <= ovf_d;
      rem_err_q     <= rem_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign a_out     = a_out_q;
  assign ovf       = ovf_q;
  assign rem_err   = rem_err_q;

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Bench for sqrt_reconstruct: directed cases plus random Q/R against an arithmetic model.
module tb_sqrt_reconstruct;

  localparam int QW = 5;
  localparam int RW = QW + 1;
  localparam int AW = 2 * QW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [QW-1:0] q_in = '0;
  logic [RW-1:0] r_in = '0;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] a_out;
  logic          ovf;
  logic          rem_err;

  int n_checks = 0;
  int n_fail   = 0;

  sqrt_reconstruct #(.QW(QW), .RW(RW), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q_in     (q_in),
    .r_in     (r_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a_out    (a_out),
    .ovf      (ovf),
    .rem_err  (rem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical definition.
  function automatic int model_a(input int q, input int r);
    return (q * q + r) % (1 << AW);
  endfunction
  function automatic int model_ovf(input int q, input int r);
    return ((q * q + r) >= (1 << AW)) ? 1 : 0;
  endfunction
  function automatic int model_rem(input int q, input int r);
    return (r > 2 * q) ? 1 : 0;
  endfunction

  // Called just after the accepting edge; expects out_valid exactly QW edges later.
  task automatic wait_result(input int q, input int r, input string tag);
    for (int k = 1; k <= QW; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, out_valid, (k == QW) ? 1 : 0);
      check({tag, "_inrdy"}, in_ready, 0);
    end
    check({tag, "_a"}, a_out, model_a(q, r));
    check({tag, "_ovf"}, ovf, model_ovf(q, r));
    check({tag, "_rem"}, rem_err, model_rem(q, r));
  endtask

  task automatic hold_and_release(input int q, input int r, input int bp, input string tag);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_inrdy"}, in_ready, 0);
      check({tag, "_hold_a"}, a_out, model_a(q, r));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, out_valid, 0);
    check({tag, "_rel_inrdy"}, in_ready, 1);
    check({tag, "_rel_a"}, a_out, model_a(q, r));
  endtask

  task automatic run_op(input int q, input int r, input int bp, input string tag);
    @(negedge clk);
    check({tag, "_idle_inrdy"}, in_ready, 1);
    q_in     = QW'(q);
    r_in     = RW'(r);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q_in     = QW'($urandom);
    r_in     = RW'($urandom);
    wait_result(q, r, tag);
    hold_and_release(q, r, bp, tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_inrdy", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_a", a_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rem", rem_err, 0);
    rst_n = 1'b1;

    // Directed cases
    run_op(5, 3, 0, "q5r3");
    run_op(31, 62, 0, "q31r62");
    run_op(31, 63, 0, "q31r63");
    run_op(0, 0, 0, "q0r0");
    run_op(2, 5, 0, "q2r5");
    run_op(12, 20, 7, "bp_q12r20");

    // Back-to-back with in_valid held high
    @(negedge clk);
    q_in     = 5'd3;
    r_in     = 6'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    q_in = 5'd7;
    r_in = 6'd14;
    wait_result(3, 1, "b2b_first");
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_gap_valid", out_valid, 0);
    check("b2b_gap_inrdy", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(7, 14, "b2b_second");
    hold_and_release(7, 14, 1, "b2b_second");

    // Reset asserted mid-RUN aborts the operation
    @(negedge clk);
    q_in     = 5'd9;
    r_in     = 6'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_inrdy", in_ready, 1);
    check("abort_a", a_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4, 0, 0, "after_abort");

    // Random operands, random backpressure
    for (int i = 0; i < 24; i++) begin
      int q, r, bp;
      q  = $urandom_range(0, (1 << QW) - 1);
      r  = $urandom_range(0, (1 << RW) - 1);
      bp = $urandom_range(0, 3);
      run_op(q, r, bp, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_reconstruct.md
Name: sqrt_reconstruct

Overview:
- Inverse companion to the combined square-root cellular array. Given an integer root Q and a remainder R, it rebuilds the radicand A = Q*Q + R.
- Built as an iterative shift-add unit that retires one bit of Q per clock, with valid/ready handshakes on both its input and output.
- Used in the datapath to check the array's root/remainder outputs against the original operand, and to regenerate operands in self-test.

Parameters:
- QW, 5: root width in bits.
- RW, QW+1: remainder width in bits. Fixed relation; do not override independently.
- AW, 2*QW: radicand (result) width in bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  Q/R operands valid.
- in_ready  output  1  block can accept operands.
- q_in  input  QW  root Q, unsigned.
- r_in  input  RW  remainder R, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- a_out  output  AW  reconstructed radicand, (Q*Q + R) mod 2^AW.
- ovf  output  1  Q*Q + R >= 2^AW.
- rem_err  output  1  R > 2*Q, i.e. not a legal integer-sqrt remainder.

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - a_out = 0, ovf = 0, rem_err = 0.
  - Internal accumulator, multiplicand, multiplier and counter all cleared.
  - Assertion mid-operation aborts immediately and the operation is lost. Deassertion takes effect at the next clk edge.
- States and transitions:
  - IDLE: in_ready = 1.
  - IDLE -> RUN on in_valid & in_ready.
    - acc (AW+1 bits) <= zero-extended r_in.
    - mcand <= q_in; mult <= q_in; cnt <= 0.
    - rem_err_reg <= (r_in > {q_in,1'b0}), compared at RW bits.
  - RUN: in_ready = 0, out_valid = 0. Each cycle:
    - if mult[0], acc <= acc + (mcand << cnt).
    - mult <= mult >> 1; cnt <= cnt + 1.
    - When cnt == QW-1, the update still applies and state -> DONE.
  - DONE: out_valid = 1.
    - a_out = acc[AW-1:0]; ovf = acc[AW]; rem_err = rem_err_reg.
    - All three stay stable while out_valid & !out_ready.
    - DONE -> IDLE on out_ready.
- Latency and throughput:
  - out_valid rises exactly QW edges after the accepting edge.
  - Throughput is one operation per QW+2 cycles minimum.
  - No overlap: in_ready = 0 in RUN and DONE. in_valid there is ignored and holds no operand.
- Output hold:
  - Outputs hold their last values in IDLE and RUN.
  - Consumers must sample only while out_valid = 1.
- Arithmetic:
  - Unsigned throughout. The accumulator is AW+1 bits, so the sum never wraps internally.
  - Legal inputs (R <= 2Q) always give ovf = 0, because Q^2 + 2Q < 2^AW.
  - ovf can only assert together with rem_err.
  - rem_err does not stop computation; the result is still produced.
- Edge values:
  - Q = 0 gives acc = R with no adds; latency is still QW cycles.
  - The shift amount cnt never exceeds QW-1.
- Simultaneous events: in_valid asserted in the same cycle as the DONE -> IDLE transition is not accepted until IDLE is reached (next cycle).

Test Plan:
- Reset, then q_in=5, r_in=3 accepted at edge e0 -> out_valid high after e5; a_out=28, ovf=0, rem_err=0.
- q_in=31, r_in=62 -> a_out=1023, ovf=0, rem_err=0.
  - q_in=31, r_in=63 -> a_out=0, ovf=1, rem_err=1.
- q_in=0, r_in=0 -> a_out=0 after 5 cycles.
  - q_in=2, r_in=5 -> a_out=9, rem_err=1, ovf=0.
- Backpressure: out_ready held low for 7 cycles after out_valid with q=12, r=20 -> a_out=164 stable, out_valid=1 throughout, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two operand sets (q=3,r=1), (q=7,r=14) -> second accepted only after the first output handshake; results 10 then 63; in_ready low from acceptance to handshake.
- Reset mid-RUN: assert rst_n=0 two cycles after accepting q=9, r=4 -> out_valid=0 and in_ready=1 immediately. New op q=4, r=0 -> a_out=16 with no residue from the aborted op.
